// File: rtl/bubble_pkg.sv
// Shared types and widths for the bubble page-buffer refill path.
package bubble_pkg;
    localparam int FLASH_ADDR_W     = 22;
    localparam int BUF_ADDR_W       = 11;
    localparam int BUF_DATA_W       = 2;
    localparam int CNT_W            = 10;  // byte counter, holds up to 2048/4
    localparam int DEF_PAGE_ENTRIES = 1024;
    localparam int DEF_BOOT_ENTRIES = 2048;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, DONE} state_e;

    typedef struct packed {
        logic                    vld;
        logic                    boot;
        logic [FLASH_ADDR_W-1:0] base;
    } grant_t;
endpackage

// File: rtl/request_arbiter.sv
// Rising-edge detection and pending flags for the two load requesters; bootloader wins.
module request_arbiter
    import bubble_pkg::*;
#(
    parameter logic [FLASH_ADDR_W-1:0] BOOT_BASE_ADDR = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    load_page_i,
    input  logic                    load_boot_i,
    input  logic [FLASH_ADDR_W-1:0] page_addr_i,
    input  logic                    take_i,
    output grant_t                  gnt_o
);
    logic                    arm_q, prev_page_q, prev_boot_q, pend_page_q, pend_boot_q;
    logic                    pend_page_d, pend_boot_d;
    logic [FLASH_ADDR_W-1:0] page_addr_q, page_addr_d;
    logic                    page_edge, boot_edge, take_boot, take_page;

    // arm_q masks the first cycle so a level held high through reset is not an edge
    assign page_edge = arm_q & load_page_i & ~prev_page_q;
    assign boot_edge = arm_q & load_boot_i & ~prev_boot_q;
    assign take_boot = take_i & pend_boot_q;
    assign take_page = take_i & ~pend_boot_q & pend_page_q;

    always_comb begin
        pend_boot_d = boot_edge | (pend_boot_q & ~take_boot);
        pend_page_d = page_edge | (pend_page_q & ~take_page);
        page_addr_d = page_edge ? page_addr_i : page_addr_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            arm_q       <= 1'b0;
            prev_page_q <= 1'b0;
            prev_boot_q <= 1'b0;
            pend_page_q <= 1'b0;
            pend_boot_q <= 1'b0;
            page_addr_q <= '0;
        end else begin
            arm_q       <= 1'b1;
            prev_page_q <= load_page_i;
            prev_boot_q <= load_boot_i;
            pend_page_q <= pend_page_d;
            pend_boot_q <= pend_boot_d;
            page_addr_q <= page_addr_d;
        end
    end

    assign gnt_o.vld  = pend_boot_q | pend_page_q;
    assign gnt_o.boot = pend_boot_q;
    assign gnt_o.base = pend_boot_q ? BOOT_BASE_ADDR : page_addr_q;
endmodule

// File: rtl/page_load_scheduler.sv
// Refills the bubble page buffer from flash: one byte per read, four 2-bit writes per byte.
// Optional WAIT watchdog with sticky load_error: define PAGE_LOAD_TIMEOUT_EN.
module page_load_scheduler
    import bubble_pkg::*;
#(
    parameter int                      PAGE_ENTRIES   = DEF_PAGE_ENTRIES,
    parameter int                      BOOT_ENTRIES   = DEF_BOOT_ENTRIES,
    parameter logic [FLASH_ADDR_W-1:0] BOOT_BASE_ADDR = 22'h000000,
    parameter int                      TIMEOUT_CYCLES = 1023
) (
    input  logic                    master_clock,
    input  logic                    reset,
    input  logic                    load_page,
    input  logic                    load_bootloader,
    input  logic [FLASH_ADDR_W-1:0] start_of_page_address,
    output logic                    flash_rd_req,
    output logic [FLASH_ADDR_W-1:0] flash_rd_addr,
    input  logic                    flash_rd_valid,
    input  logic [7:0]              flash_rd_data,
    output logic [BUF_ADDR_W-1:0]   bubble_buffer_write_address,
    output logic [BUF_DATA_W-1:0]   bubble_buffer_data_input,
    output logic                    bubble_buffer_write_enable,
    output logic                    busy,
    output logic                    load_done,
    output logic                    load_error
);
    localparam logic [CNT_W-1:0] PAGE_BYTES = CNT_W'(PAGE_ENTRIES / 4);
    localparam logic [CNT_W-1:0] BOOT_BYTES = CNT_W'(BOOT_ENTRIES / 4);

    if (PAGE_ENTRIES % 4 != 0 || PAGE_ENTRIES < 4 || PAGE_ENTRIES > 2048 ||
        BOOT_ENTRIES % 4 != 0 || BOOT_ENTRIES < 4 || BOOT_ENTRIES > 2048 ||
        TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("page_load_scheduler: illegal parameter value");
    end

    state_e                  state_q, state_d;
    logic [FLASH_ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]        nbytes_q, nbytes_d, idx_q, idx_d;
    logic [BUF_ADDR_W-1:0]   waddr_q, waddr_d;
    logic [1:0]              sub_q, sub_d;
    logic [7:0]              data_q, data_d;
    logic                    take;
    grant_t                  gnt;

    request_arbiter #(.BOOT_BASE_ADDR(BOOT_BASE_ADDR)) u_arb (
        .clk_i       (master_clock),
        .rst_i       (reset),
        .load_page_i (load_page),
        .load_boot_i (load_bootloader),
        .page_addr_i (start_of_page_address),
        .take_i      (take),
        .gnt_o       (gnt)
    );

`ifdef PAGE_LOAD_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;

    always_ff @(posedge master_clock or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
    assign load_error = err_q;
`else
    assign load_error = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        nbytes_d = nbytes_q;
        idx_d    = idx_q;
        waddr_d  = waddr_q;
        sub_d    = sub_q;
        data_d   = data_q;
        take     = 1'b0;
`ifdef PAGE_LOAD_TIMEOUT_EN
        tmo_d    = tmo_q;
        err_d    = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (gnt.vld) begin
                    take     = 1'b1;
                    base_d   = gnt.base;
                    nbytes_d = gnt.boot ? BOOT_BYTES : PAGE_BYTES;
                    idx_d    = '0;
                    waddr_d  = '0;
                    sub_d    = '0;
`ifdef PAGE_LOAD_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                    state_d  = REQ;
                end
            end
            REQ: begin
`ifdef PAGE_LOAD_TIMEOUT_EN
                tmo_d   = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (flash_rd_valid) begin
                    data_d  = flash_rd_data;
                    sub_d   = '0;
                    state_d = WRITE;
                end
`ifdef PAGE_LOAD_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    tmo_d   = tmo_q + TMO_W'(1);
                end
`endif
            end
            WRITE: begin
                waddr_d = waddr_q + BUF_ADDR_W'(1);
                sub_d   = sub_q + 2'd1;
                if (sub_q == 2'd3) begin
                    idx_d   = idx_q + CNT_W'(1);
                    state_d = (idx_d == nbytes_q) ? DONE : REQ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge master_clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            base_q   <= '0;
            nbytes_q <= '0;
            idx_q    <= '0;
            waddr_q  <= '0;
            sub_q    <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            nbytes_q <= nbytes_d;
            idx_q    <= idx_d;
            waddr_q  <= waddr_d;
            sub_q    <= sub_d;
            data_q   <= data_d;
        end
    end

    // Outputs decode straight from the state register so reset silences them at once
    assign flash_rd_req                = (state_q == REQ) || (state_q == WAIT);
    assign flash_rd_addr               = base_q + FLASH_ADDR_W'(idx_q);
    assign bubble_buffer_write_enable  = (state_q == WRITE);
    assign bubble_buffer_write_address = waddr_q;
    assign bubble_buffer_data_input    = data_q[{sub_q, 1'b0} +: BUF_DATA_W];
    assign busy                        = flash_rd_req || bubble_buffer_write_enable;
    assign load_done                   = (state_q == DONE);
endmodule

// File: tb/tb_page_load_scheduler.sv
// Directed bench for page_load_scheduler; flash returns addr[7:0]^0xE4 one cycle after req.
module tb_page_load_scheduler;
    localparam logic [21:0] BOOT_BASE = 22'h3FFF80;
    localparam int          MSK       = 16383;

    logic        master_clock = 1'b0;
    logic        reset;
    logic        load_page, load_bootloader;
    logic [21:0] start_of_page_address;
    logic        flash_rd_req;
    logic [21:0] flash_rd_addr;
    logic        flash_rd_valid;
    logic [7:0]  flash_rd_data;
    logic [10:0] bubble_buffer_write_address;
    logic [1:0]  bubble_buffer_data_input;
    logic        bubble_buffer_write_enable, busy, load_done, load_error;
    logic        flash_en;

    page_load_scheduler #(
        .PAGE_ENTRIES(1024), .BOOT_ENTRIES(2048),
        .BOOT_BASE_ADDR(BOOT_BASE), .TIMEOUT_CYCLES(16)
    ) dut (
        .master_clock(master_clock), .reset(reset),
        .load_page(load_page), .load_bootloader(load_bootloader),
        .start_of_page_address(start_of_page_address),
        .flash_rd_req(flash_rd_req), .flash_rd_addr(flash_rd_addr),
        .flash_rd_valid(flash_rd_valid), .flash_rd_data(flash_rd_data),
        .bubble_buffer_write_address(bubble_buffer_write_address),
        .bubble_buffer_data_input(bubble_buffer_data_input),
        .bubble_buffer_write_enable(bubble_buffer_write_enable),
        .busy(busy), .load_done(load_done), .load_error(load_error)
    );

    always #5 master_clock = ~master_clock;

    always @(posedge master_clock or posedge reset) begin
        if (reset) begin
            flash_rd_valid <= 1'b0;
            flash_rd_data  <= 8'h00;
        end else begin
            flash_rd_valid <= 1'b0;
            if (flash_en && flash_rd_req && !flash_rd_valid) begin
                flash_rd_valid <= 1'b1;
                flash_rd_data  <= flash_rd_addr[7:0] ^ 8'hE4;
            end
        end
    end

    int wr_addr[0:MSK];
    int wr_data[0:MSK];
    int rd_addr[0:MSK];
    int done_wr[0:63];
    int wr_n = 0, rd_n = 0, req_n = 0, done_n = 0, bad_n = 0;

    always @(negedge master_clock) begin
        if (bubble_buffer_write_enable) begin
            wr_addr[wr_n & MSK] <= int'(bubble_buffer_write_address);
            wr_data[wr_n & MSK] <= int'(bubble_buffer_data_input);
            wr_n <= wr_n + 1;
        end
        if (flash_rd_req && flash_rd_valid) begin
            rd_addr[rd_n & MSK] <= int'(flash_rd_addr);
            rd_n <= rd_n + 1;
        end
        if (flash_rd_req) req_n <= req_n + 1;
        if (load_done) begin
            done_wr[done_n & 63] <= wr_n;
            done_n <= done_n + 1;
        end
        if (((bubble_buffer_write_enable || flash_rd_req) && !busy) || (load_done && busy))
            bad_n <= bad_n + 1;
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    endtask

    task automatic pulse(input logic boot, input logic page, input logic [21:0] a);
        @(negedge master_clock);
        load_bootloader       = boot;
        load_page             = page;
        start_of_page_address = a;
        @(negedge master_clock);
        load_bootloader = 1'b0;
        load_page       = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        int k;
        k = 0;
        while (done_n < target && k < budget) begin
            @(posedge master_clock);
            k++;
        end
        chk(tag, done_n, target);
        @(negedge master_clock);
    endtask

    // Read sequence and write address/data sequence of one load against the flash pattern
    task automatic chk_load(input string tag, input int w0, input int r0, input int nbytes,
                            input logic [21:0] base);
        int rerr, werr, idx;
        logic [21:0] a;
        logic [7:0]  b;
        rerr = 0;
        werr = 0;
        for (int k = 0; k < nbytes; k++) begin
            a = base + 22'(k);
            b = a[7:0] ^ 8'hE4;
            if (rd_addr[(r0 + k) & MSK] != int'(a)) rerr++;
            for (int j = 0; j < 4; j++) begin
                idx = (w0 + 4 * k + j) & MSK;
                if (wr_addr[idx] != 4 * k + j) werr++;
                if (wr_data[idx] != int'((b >> (2 * j)) & 8'h03)) werr++;
            end
        end
        chk({tag, "_rd_seq_errs"}, rerr, 0);
        chk({tag, "_wr_seq_errs"}, werr, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, r0, d0, b0, q0, k;
        reset                 = 1'b1;
        load_page             = 1'b1;
        load_bootloader       = 1'b0;
        start_of_page_address = 22'h001000;
        flash_en              = 1'b1;
        repeat (3) @(negedge master_clock);
        chk("rst_req", flash_rd_req, 0);
        chk("rst_we", bubble_buffer_write_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", load_done, 0);
        chk("rst_err", load_error, 0);
        chk("rst_waddr", bubble_buffer_write_address, 0);
        chk("rst_raddr", flash_rd_addr, 0);
        reset = 1'b0;
        repeat (5) @(negedge master_clock);
        chk("held_level_no_edge", busy, 0);
        load_page = 1'b0;
        @(negedge master_clock);

        // Page load from 0x001000
        w0 = wr_n; r0 = rd_n; d0 = done_n; b0 = bad_n;
        pulse(1'b0, 1'b1, 22'h001000);
        wait_done("page_done", d0 + 1, 3000);
        repeat (20) @(negedge master_clock);
        chk("page_nwr", wr_n - w0, 1024);
        chk("page_nrd", rd_n - r0, 256);
        chk("page_rd_first", rd_addr[r0 & MSK], 32'h001000);
        chk("page_rd_last", rd_addr[(r0 + 255) & MSK], 32'h0010FF);
        chk("page_e4_order", {wr_data[(w0 + 3) & MSK][1:0], wr_data[(w0 + 2) & MSK][1:0],
                              wr_data[(w0 + 1) & MSK][1:0], wr_data[w0 & MSK][1:0]}, 8'hE4);
        chk("page_one_done", done_n - d0, 1);
        chk("page_idle_busy", busy, 0);
        chk_load("page", w0, r0, 256, 22'h001000);

        // Bootloader load; base near top of flash so the read address wraps
        w0 = wr_n; r0 = rd_n; d0 = done_n;
        pulse(1'b1, 1'b0, 22'h155555);
        wait_done("boot_done", d0 + 1, 5000);
        repeat (5) @(negedge master_clock);
        chk("boot_nwr", wr_n - w0, 2048);
        chk("boot_nrd", rd_n - r0, 512);
        chk("boot_rd_wrap", rd_addr[(r0 + 128) & MSK], 32'h000000);
        chk("boot_last_waddr", wr_addr[(w0 + 2047) & MSK], 2047);
        chk_load("boot", w0, r0, 512, BOOT_BASE);
        chk("busy_coherent", bad_n - b0, 0);

        // Simultaneous edges: bootloader first, then page, no interleaving
        w0 = wr_n; r0 = rd_n; d0 = done_n;
        pulse(1'b1, 1'b1, 22'h2A0000);
        wait_done("sim_done", d0 + 2, 8000);
        chk("sim_first_done_at", done_wr[d0 & 63] - w0, 2048);
        chk("sim_second_done_at", done_wr[(d0 + 1) & 63] - w0, 3072);
        chk_load("sim_boot", w0, r0, 512, BOOT_BASE);
        chk_load("sim_page", w0 + 2048, r0 + 512, 256, 22'h2A0000);

        // Requests during a load: B then C coalesce, C's address wins
        w0 = wr_n; r0 = rd_n; d0 = done_n;
        pulse(1'b0, 1'b1, 22'h100000);
        repeat (60) @(negedge master_clock);
        pulse(1'b0, 1'b1, 22'h200000);
        repeat (60) @(negedge master_clock);
        pulse(1'b0, 1'b1, 22'h300000);
        wait_done("mid_done", d0 + 2, 5000);
        repeat (200) @(negedge master_clock);
        chk("mid_two_loads", done_n - d0, 2);
        chk("mid_first_base", rd_addr[r0 & MSK], 32'h100000);
        chk("mid_second_base", rd_addr[(r0 + 256) & MSK], 32'h300000);
        chk_load("mid_a", w0, r0, 256, 22'h100000);
        chk_load("mid_c", w0 + 1024, r0 + 256, 256, 22'h300000);

        // Reset in the middle of WRITE
        d0 = done_n;
        pulse(1'b0, 1'b1, 22'h000400);
        k = 0;
        while (!(bubble_buffer_write_enable && bubble_buffer_write_address >= 11'd6) && k < 500) begin
            @(negedge master_clock);
            k++;
        end
        chk("rstmid_in_write", bubble_buffer_write_enable, 1);
        reset = 1'b1;
        #1;
        chk("rstmid_we", bubble_buffer_write_enable, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_req", flash_rd_req, 0);
        repeat (2) @(negedge master_clock);
        reset = 1'b0;
        repeat (3) @(negedge master_clock);
        chk("rstmid_no_done", done_n - d0, 0);
        w0 = wr_n; r0 = rd_n; d0 = done_n;
        pulse(1'b0, 1'b1, 22'h000800);
        wait_done("after_rst_done", d0 + 1, 3000);
        chk("after_rst_waddr0", wr_addr[w0 & MSK], 0);
        chk("after_rst_nwr", wr_n - w0, 1024);
        chk_load("after_rst", w0, r0, 256, 22'h000800);

`ifdef PAGE_LOAD_TIMEOUT_EN
        // Flash never answers: 1 REQ + 16 WAIT cycles of req, then error and done
        flash_en = 1'b0;
        w0 = wr_n; d0 = done_n; q0 = req_n;
        pulse(1'b0, 1'b1, 22'h000C00);
        wait_done("tmo_done", d0 + 1, 500);
        repeat (5) @(negedge master_clock);
        chk("tmo_req_cycles", req_n - q0, 17);
        chk("tmo_req_dropped", flash_rd_req, 0);
        chk("tmo_error_set", load_error, 1);
        chk("tmo_no_writes", wr_n - w0, 0);
        chk("tmo_one_done", done_n - d0, 1);
        flash_en = 1'b1;
        d0 = done_n;
        pulse(1'b0, 1'b1, 22'h000C00);
        repeat (2) @(negedge master_clock);
        chk("tmo_error_cleared", load_error, 0);
        wait_done("tmo_next_done", d0 + 1, 3000);
`else
        chk("no_tmo_error", load_error, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
